lb_dispatcher: RTL and testbench
================================

// Module: lb_dispatcher
// PURPOSE
//  Round-robin request scheduler for the load balancer. Accepts one request at a time on a
//  valid/ready input, picks the next worker with free capacity, and forwards the request on
//  that worker's output channel. Per-worker outstanding-request counters (saturating up/down)
//  gate eligibility. Workers return capacity with a 1-cycle done pulse.
// PARAMETERS
//  NUM_WORKERS  4   number of downstream workers (>=2)
//  DATA_BITS    32  request payload width
//  CREDIT_BITS  2   outstanding counter width; MAX_OUT = 2**CREDIT_BITS-1 requests per worker
// PORTS
//  clk          in   1                        clock, all logic rising-edge
//  reset        in   1                        synchronous, active-high reset
//  in_valid     in   1                        request available
//  in_ready     out  1                        dispatcher can accept request this cycle
//  in_data      in   DATA_BITS                request payload
//  out_valid    out  NUM_WORKERS              one-hot: request presented to worker i
//  out_ready    in   NUM_WORKERS              worker i accepts presented request
//  out_data     out  DATA_BITS                payload, shared by all worker channels
//  out_sel      out  $clog2(NUM_WORKERS)      index of currently/last granted worker
//  done         in   NUM_WORKERS              1-cycle pulse: worker i finished one request
//  outstanding  out  NUM_WORKERS*CREDIT_BITS  packed counters, worker i at [i*CREDIT_BITS +: CREDIT_BITS]
//  err          out  1                        sticky: done seen on worker with outstanding==0
// BEHAVIOUR
//  Reset (reset=1 at edge): state=IDLE, out_valid=0, out_data=0, out_sel=0, all outstanding=0,
//   err=0, rr pointer=NUM_WORKERS-1 (so first grant goes to worker 0). Reset wins over all events.
//  Eligible(i) = outstanding[i] < MAX_OUT.
//  FSM, 2 states:
//   IDLE: in_ready = |eligible (combinational). On in_valid & in_ready at edge T:
//     sel = first eligible index searching ptr+1, ptr+2, ... modulo NUM_WORKERS;
//     latch out_data<=in_data, out_sel<=sel, ptr<=sel, outstanding[sel]++; go HOLD.
//   HOLD: in_ready=0; out_valid[out_sel]=1 from T+1. On out_ready[out_sel] at edge: out_valid<=0,
//     go IDLE. out_ready of non-selected workers ignored. out_data stable throughout HOLD.
//  Latency: input accept to out_valid = 1 cycle. Max throughput: 1 request per 2 cycles.
//  Counter is incremented at accept (not at downstream handshake); a request in HOLD counts as
//   outstanding.
//  done[i]: outstanding[i]-- at edge, in any state. Multiple done bits same cycle all applied.
//  Increment and done on same worker same edge: counter unchanged.
//  done[i] with outstanding[i]==0 (and no same-edge increment): counter stays 0, err<=1 (sticky
//   until reset). Counters never wrap: increment only occurs when eligible, so max is MAX_OUT.
//  All workers at MAX_OUT: in_ready=0; in_valid held by upstream, no state change until a done.
//  Pointer wrap: search from ptr+1 wraps NUM_WORKERS-1 -> 0; if only ptr itself eligible, it is
//   re-granted.
//  Reset mid-HOLD: request dropped, out_valid=0 next cycle, counters cleared.
//  in_data/in_valid changes while in_ready=0 have no effect.
// TESTING  (NUM_WORKERS=4, CREDIT_BITS=2, MAX_OUT=3, out_ready tied 1 unless stated)
//  1 Reset then 4 back-to-back requests 0xA0..0xA3 -> grants to workers 0,1,2,3 in order,
//    out_valid one cycle after each accept, outstanding = {1,1,1,1}, in_ready toggles 1/0.
//  2 12 requests, no done -> each worker reaches 3; 13th: in_ready=0 held; done[2] pulse ->
//    in_ready=1 next cycle, 13th request goes to worker 2, outstanding[2]=3 again.
//  3 outstanding={3,0,3,3}, ptr=3 -> next request skips to worker 1; following goes to 1 again
//    (only eligible), pointer wraps correctly.
//  4 out_ready[sel]=0 for 5 cycles in HOLD -> out_valid and out_data stable, in_ready=0 for all
//    5 cycles; other workers' out_ready ignored; done pulses during HOLD still decrement.
//  5 Accept to worker 1 in same cycle as done[1] with outstanding[1]=2 -> outstanding[1]=2;
//    done[3] with outstanding[3]=0 -> err=1 and stays 1, outstanding[3]=0.
//  6 reset asserted during HOLD -> next cycle out_valid=0, outstanding all 0, err=0, next request
//    granted to worker 0.

Source files
------------

// File: rtl/lb_dispatcher.sv
// Round-robin request dispatcher: one request in flight at a time, forwarded to the next
// worker whose saturating outstanding counter is below its limit.
module lb_dispatcher #(
    parameter int unsigned NUM_WORKERS = 4,
    parameter int unsigned DATA_BITS   = 32,
    parameter int unsigned CREDIT_BITS = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DATA_BITS-1:0]              in_data,
    output logic [NUM_WORKERS-1:0]            out_valid,
    input  logic [NUM_WORKERS-1:0]            out_ready,
    output logic [DATA_BITS-1:0]              out_data,
    output logic [$clog2(NUM_WORKERS)-1:0]    out_sel,
    input  logic [NUM_WORKERS-1:0]            done,
    output logic [NUM_WORKERS*CREDIT_BITS-1:0] outstanding,
    output logic                              err
);

    localparam int unsigned SEL_BITS = $clog2(NUM_WORKERS);
    localparam logic [CREDIT_BITS-1:0] MAX_OUT = '1;

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                state, state_next;
    logic [CREDIT_BITS-1:0] cnt      [NUM_WORKERS];
    logic [CREDIT_BITS-1:0] cnt_next [NUM_WORKERS];
    logic [SEL_BITS-1:0]   ptr;
    logic [SEL_BITS-1:0]   sel, sel_hi, sel_lo;
    logic                  found_hi, found_lo;
    logic [NUM_WORKERS-1:0] eligible;
    logic                  accept;
    logic                  err_set;

    // Rotating search from ptr+1: lowest eligible index above ptr wins, else lowest at/below ptr.
    always_comb begin
        eligible = '0;
        found_hi = 1'b0;
        found_lo = 1'b0;
        sel_hi   = '0;
        sel_lo   = '0;
        for (int unsigned i = 0; i < NUM_WORKERS; i++) begin
            eligible[i] = (cnt[i] != MAX_OUT);
            if (eligible[i] && SEL_BITS'(i) > ptr && !found_hi) begin
                found_hi = 1'b1;
                sel_hi   = SEL_BITS'(i);
            end
            if (eligible[i] && SEL_BITS'(i) <= ptr && !found_lo) begin
                found_lo = 1'b1;
                sel_lo   = SEL_BITS'(i);
            end
        end
        sel = found_hi ? sel_hi : sel_lo;
    end

    always_comb begin
        state_next = state;
        out_valid  = '0;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = |eligible;
                if (in_valid && (|eligible)) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid[out_sel] = 1'b1;
                if (out_ready[out_sel]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign accept = in_valid && in_ready;

    // Accept and done on the same worker cancel; done on an empty counter flags an error.
    always_comb begin
        err_set     = 1'b0;
        outstanding = '0;
        for (int unsigned i = 0; i < NUM_WORKERS; i++) begin
            cnt_next[i] = cnt[i];
            if (accept && sel == SEL_BITS'(i) && !done[i]) begin
                cnt_next[i] = cnt[i] + 1'b1;
            end else if (!(accept && sel == SEL_BITS'(i)) && done[i]) begin
                if (cnt[i] != '0) begin
                    cnt_next[i] = cnt[i] - 1'b1;
                end else begin
                    err_set = 1'b1;
                end
            end
            outstanding[i*CREDIT_BITS +: CREDIT_BITS] = cnt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            out_data <= '0;
            out_sel  <= '0;
            ptr      <= SEL_BITS'(NUM_WORKERS - 1);
            err      <= 1'b0;
            for (int unsigned i = 0; i < NUM_WORKERS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            state <= state_next;
            if (accept) begin
                out_data <= in_data;
                out_sel  <= sel;
                ptr      <= sel;
            end
            for (int unsigned i = 0; i < NUM_WORKERS; i++) begin
                cnt[i] <= cnt_next[i];
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_lb_dispatcher.sv
// Scoreboard bench for lb_dispatcher: stimulus queues expected grants, a forked monitor
// checks every presented output against them.
module tb_lb_dispatcher;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [1:0]  out_sel;
    logic [3:0]  done;
    logic [7:0]  outstanding;
    logic        err;

    typedef struct {
        int unsigned w;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    lb_dispatcher #(.NUM_WORKERS(4), .DATA_BITS(32), .CREDIT_BITS(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel),
        .done(done), .outstanding(outstanding), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        logic prev = 1'b0;
        logic have = 1'b0;
        exp_t cur;
        forever begin
            @(negedge clk);
            if (out_valid != 4'b0) begin
                if (!prev) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        have = 1'b0;
                        $display("FAIL unexpected_grant: out_valid=0x%0h with empty queue at %0t", out_valid, $time);
                    end else begin
                        cur  = exp_q.pop_front();
                        have = 1'b1;
                    end
                end
                if (have) begin
                    check("mon_out_valid", out_valid, 4'b0001 << cur.w);
                    check("mon_out_sel", out_sel, cur.w);
                    check("mon_out_data", out_data, cur.d);
                    check("mon_in_ready_hold", in_ready, 1'b0);
                end
            end
            prev = (out_valid != 4'b0);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        done      = '0;
        out_ready = '1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send(input logic [31:0] d, input int unsigned w);
        int unsigned waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check("accept_timeout", in_ready, 1'b1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back('{w, d});
        @(negedge clk);
        in_valid = 1'b0;
        check("accept_latency", out_valid, 4'b0001 << w);
    endtask

    task automatic pulse_done(input logic [3:0] m);
        done = m;
        @(negedge clk);
        done = '0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        done      = '0;
        out_ready = '1;
        fork
            monitor();
        join_none

        // 1: reset state, then one grant per worker in order
        do_reset();
        check("rst_out_valid", out_valid, 4'b0);
        check("rst_out_sel", out_sel, 2'd0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_outstanding", outstanding, 8'h00);
        check("rst_err", err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        for (int unsigned i = 0; i < 4; i++) send(32'hA0 + i, i);
        check("t1_outstanding", outstanding, 8'h55);

        // 2: fill every worker, then stall until a done frees worker 2
        for (int unsigned i = 0; i < 8; i++) send(32'hB0 + i, i % 4);
        @(negedge clk);
        check("t2_full", outstanding, 8'hFF);
        in_valid = 1'b1;
        in_data  = 32'hBD;
        for (int unsigned i = 0; i < 3; i++) begin
            check("t2_stall_ready", in_ready, 1'b0);
            @(negedge clk);
        end
        check("t2_stall_cnt", outstanding, 8'hFF);
        pulse_done(4'b0100);
        check("t2_ready_after_done", in_ready, 1'b1);
        exp_q.push_back('{2, 32'hBD});
        @(negedge clk);
        in_valid = 1'b0;
        check("t2_refill", outstanding, 8'hFF);

        // 3: ptr=3, only worker 1 free -> skip to 1, then re-grant 1
        pulse_done(4'b1000);
        send(32'hC0, 3);
        pulse_done(4'b0010);
        pulse_done(4'b0010);
        pulse_done(4'b0010);
        check("t3_setup", outstanding, 8'hF3);
        send(32'hC1, 1);
        send(32'hC2, 1);
        send(32'hC3, 1);
        @(negedge clk);
        check("t3_full", outstanding, 8'hFF);
        check("t3_ready", in_ready, 1'b0);

        // 4: held HOLD with foreign out_ready high and a done in the middle
        pulse_done(4'b0001);
        out_ready = 4'b1110;
        send(32'hD0, 0);
        for (int unsigned k = 0; k < 5; k++) begin
            check("t4_hold_valid", out_valid, 4'b0001);
            check("t4_hold_data", out_data, 32'hD0);
            check("t4_hold_ready", in_ready, 1'b0);
            if (k == 1) done = 4'b0100;
            if (k == 2) done = 4'b0000;
            @(negedge clk);
        end
        check("t4_done_in_hold", outstanding, 8'hEF);
        out_ready = '1;
        @(negedge clk);
        check("t4_release_valid", out_valid, 4'b0);
        check("t4_release_ready", in_ready, 1'b1);

        // 5: accept and done on the same worker; done on empty counter sets err
        do_reset();
        for (int unsigned i = 0; i < 9; i++) send(32'h10 + i, i % 4);
        @(negedge clk);
        check("t5_setup", outstanding, 8'hAB);
        in_valid = 1'b1;
        in_data  = 32'hE9;
        done     = 4'b0010;
        check("t5_ready", in_ready, 1'b1);
        exp_q.push_back('{1, 32'hE9});
        @(negedge clk);
        in_valid = 1'b0;
        done     = '0;
        check("t5_inc_dec_cancel", outstanding, 8'hAB);
        pulse_done(4'b1000);
        pulse_done(4'b1000);
        check("t5_drain_cnt", outstanding, 8'h2B);
        check("t5_err_clear", err, 1'b0);
        pulse_done(4'b1000);
        check("t5_err_set", err, 1'b1);
        check("t5_no_wrap", outstanding, 8'h2B);
        send(32'hEA, 2);
        @(negedge clk);
        check("t5_err_sticky", err, 1'b1);

        // 6: reset in the middle of HOLD
        out_ready = '0;
        send(32'hF0, 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6_out_valid", out_valid, 4'b0);
        check("t6_outstanding", outstanding, 8'h00);
        check("t6_err", err, 1'b0);
        check("t6_out_sel", out_sel, 2'd0);
        out_ready = '1;
        send(32'h60, 0);
        @(negedge clk);
        @(negedge clk);
        check("t6_outstanding_after", outstanding, 8'h01);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
